// File: rtl/fma_pkg.sv
// Shared FMAdd constants, helpers and payload types.
package fma_pkg;

    // Count width able to hold w-1 (the largest leading-zero count of a w-bit value).
    function automatic int unsigned lz_cnt_w(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned WIDTH = 50;
    localparam int unsigned CNT_W = lz_cnt_w(WIDTH);

    // Output-stage payload of the LZA pipe.
    typedef struct packed {
        logic [CNT_W-1:0] est;
        logic [CNT_W-1:0] cnt;
        logic             corr;
        logic             zero;
    } lza_res_t;

endpackage

// File: rtl/lza_pri_enc.sv
// MSB-first priority encoder: est_c = WIDTH-1 - index of the highest set bit of f.
module lza_pri_enc #(
    parameter int unsigned WIDTH = 50,
    parameter int unsigned CNT_W = 6
)(
    input  logic [WIDTH-1:0] f,
    output logic [CNT_W-1:0] est_c
);

    // Ascending scan; the last hit is the highest set bit. f[0] is always set upstream.
    always_comb begin
        est_c = CNT_W'(WIDTH - 1);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (f[i]) begin
                est_c = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lza_pipe.sv
// Three-stage leading-zero anticipator with one-bit correction for the FMAdd normalise path.
module lza_pipe
    import fma_pkg::*;
#(
    parameter int unsigned WIDTH = fma_pkg::WIDTH,
    parameter int unsigned CNT_W = fma_pkg::CNT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] est_count,
    output logic [CNT_W-1:0] ld_count,
    output logic             corr,
    output logic             sum_zero
);

    logic [WIDTH-1:0] gVec, tVec, zVec, fVec;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] f1, sum1, sum2, shifted;
    logic [CNT_W-1:0] est2, estNext;
    logic             load2, load3;
    lza_res_t         res3, res3Next;

    // Indicator vector: marks candidate leading-digit positions of opA+opB.
    always_comb begin
        gVec = opA & opB;
        tVec = opA ^ opB;
        zVec = ~(opA | opB);
        fVec = '0;
        fVec[WIDTH-1] = ~tVec[WIDTH-1] & tVec[WIDTH-2];
        for (int j = 1; j < int'(WIDTH) - 1; j++) begin
            fVec[j] = tVec[j+1] ? ((gVec[j] & ~zVec[j-1]) | (zVec[j] & ~gVec[j-1]))
                                : ((zVec[j] & ~zVec[j-1]) | (gVec[j] & ~gVec[j-1]));
        end
        fVec[0] = 1'b1;
    end

    // Ready chain from the output back to the input, so a draining pipe never bubbles.
    always_comb begin
        load3    = ~v3 | out_ready;
        load2    = ~v2 | load3;
        in_ready = ~v1 | load2;
    end

    lza_pri_enc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) uPriEnc (
        .f     (f1),
        .est_c (estNext)
    );

    // Off-by-one fix: if the anticipated leading bit of the sum is 0, the true count is one more.
    always_comb begin
        shifted       = sum2 << est2;
        res3Next.est  = est2;
        res3Next.zero = (sum2 == '0);
        res3Next.cnt  = est2;
        res3Next.corr = 1'b0;
        if ((est2 < CNT_W'(WIDTH - 1)) && !shifted[WIDTH-1]) begin
            res3Next.cnt  = est2 + CNT_W'(1);
            res3Next.corr = 1'b1;
        end
    end

    // Stage valid bits; flush empties every stage and drops a same-cycle input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (in_ready) v1 <= in_valid;
            if (load2)    v2 <= v1;
            if (load3)    v3 <= v2;
        end
    end

    // Stage data; only loaded when a valid entry moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f1   <= '0;
            sum1 <= '0;
            est2 <= '0;
            sum2 <= '0;
            res3 <= '0;
        end else begin
            if (in_ready && in_valid) begin
                f1   <= fVec;
                sum1 <= opA + opB;
            end
            if (load2 && v1) begin
                est2 <= estNext;
                sum2 <= sum1;
            end
            if (load3 && v2) begin
                res3 <= res3Next;
            end
        end
    end

    assign out_valid = v3;
    assign est_count = res3.est;
    assign ld_count  = res3.cnt;
    assign corr      = res3.corr;
    assign sum_zero  = res3.zero;

endmodule

// File: tb/tb_lza_pipe.sv
// Randomised and directed bench for lza_pipe against a bit-level reference model.
module tb_lza_pipe;

    localparam int W  = 50;
    localparam int CW = 6;

    typedef struct {
        logic [CW-1:0] est;
        logic [CW-1:0] ld;
        logic          corr;
        logic          zero;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready;
    logic [W-1:0]  opA, opB;
    logic [CW-1:0] est_count, ld_count;
    logic          corr, sum_zero;

    int            nChecks = 0;
    int            nErrors = 0;
    exp_t          q[$];
    logic          stallPrev = 1'b0;
    logic [2*CW+1:0] heldOut = '0;

    lza_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .est_count (est_count),
        .ld_count  (ld_count),
        .corr      (corr),
        .sum_zero  (sum_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkEq(input string tag, input longint got, input longint exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: evaluate the indicator per bit, take the top hit, then fix against the true sum.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic [W-1:0] s;
        int hi, est;
        logic fb, tp, gj, zj, gm, zm;
        s  = a + b;
        hi = 0;
        for (int j = W - 1; j >= 1; j--) begin
            if (j == W - 1) begin
                fb = ((a[j] ^ b[j]) == 1'b0) && ((a[j-1] ^ b[j-1]) == 1'b1);
            end else begin
                tp = a[j+1] ^ b[j+1];
                gj = a[j] & b[j];     zj = ~a[j] & ~b[j];
                gm = a[j-1] & b[j-1]; zm = ~a[j-1] & ~b[j-1];
                fb = tp ? ((gj && !zm) || (zj && !gm)) : ((zj && !zm) || (gj && !gm));
            end
            if (fb) begin
                hi = j;
                break;
            end
        end
        est    = W - 1 - hi;
        r.est  = CW'(est);
        r.zero = (s == '0);
        if (est < W - 1 && s[W-1-est] == 1'b0) begin
            r.ld = CW'(est + 1); r.corr = 1'b1;
        end else begin
            r.ld = CW'(est);     r.corr = 1'b0;
        end
        return r;
    endfunction

    // One clock: drive at negedge, score the handshakes that will fire at the next posedge.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ordy, input logic fl, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv; opA = a; opB = b; out_ready = ordy; flush = fl;
        #1;
        if (stallPrev) begin
            checkEq("hold_valid", longint'(out_valid), 1);
            checkEq("hold_data", longint'({est_count, ld_count, corr, sum_zero}), longint'(heldOut));
        end
        if (out_valid && out_ready) begin
            checkEq("out_has_entry", longint'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                checkEq("est_count", longint'(est_count), longint'(e.est));
                checkEq("ld_count", longint'(ld_count), longint'(e.ld));
                checkEq("corr", longint'(corr), longint'(e.corr));
                checkEq("sum_zero", longint'(sum_zero), longint'(e.zero));
            end
        end
        acc = in_valid && in_ready && !fl;
        if (fl) q.delete();
        else if (acc) q.push_back(refModel(a, b));
        checkEq("depth", longint'(q.size() <= 3), 1);
        stallPrev = out_valid && !out_ready && !fl;
        heldOut   = {est_count, ld_count, corr, sum_zero};
        @(posedge clk);
    endtask

    // Idle with out_ready low until out_valid rises; returns cycles since the accepting edge.
    task automatic waitOut(output int lat);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
        end
        stallPrev = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        for (int c = 0; c < 20 && (q.size() > 0 || out_valid); c++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        checkEq("drained", longint'(q.size()), 0);
    endtask

    function automatic logic [W-1:0] randOp(input logic [W-1:0] other);
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: return t[W-1:0];
            1: return -other + W'($urandom_range(0, 15));
            2: return t[W-1:0] >> $urandom_range(0, W - 1);
            default: return ($urandom_range(0, 1) != 0) ? other : '0;
        endcase
    endfunction

    initial begin
        logic acc;
        int lat, k;
        logic [W-1:0] va[5], vb[5], ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; opA = '0; opB = '0;
        #13;
        checkEq("rst_out_valid", longint'(out_valid), 0);
        checkEq("rst_est", longint'(est_count), 0);
        checkEq("rst_ld", longint'(ld_count), 0);
        checkEq("rst_corr", longint'(corr), 0);
        checkEq("rst_zero", longint'(sum_zero), 0);
        @(negedge clk); rst_n = 1'b1; #1;
        checkEq("rst_in_ready", longint'(in_ready), 1);

        // Case 1: equal operands, no correction, 3-cycle latency.
        step(1'b1, W'(1) << 47, W'(1) << 47, 1'b0, 1'b0, acc);
        checkEq("t1_accept", longint'(acc), 1);
        waitOut(lat);
        checkEq("t1_latency", longint'(lat), 3);
        checkEq("t1_est", longint'(est_count), 1);
        checkEq("t1_ld", longint'(ld_count), 1);
        checkEq("t1_corr", longint'(corr), 0);
        checkEq("t1_zero", longint'(sum_zero), 0);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Case 2: estimate one short, corrected.
        step(1'b1, W'(1) << 40, '0, 1'b0, 1'b0, acc);
        waitOut(lat);
        checkEq("t2_est", longint'(est_count), 8);
        checkEq("t2_ld", longint'(ld_count), 9);
        checkEq("t2_corr", longint'(corr), 1);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Case 3: zero sum saturates.
        step(1'b1, '0, '0, 1'b0, 1'b0, acc);
        waitOut(lat);
        checkEq("t3_est", longint'(est_count), 49);
        checkEq("t3_ld", longint'(ld_count), 49);
        checkEq("t3_corr", longint'(corr), 0);
        checkEq("t3_zero", longint'(sum_zero), 1);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);

        // Case 4: backpressure with 5 queued vectors.
        for (int i = 0; i < 5; i++) begin
            va[i] = randOp('0); vb[i] = randOp(va[i]);
        end
        k = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, va[k], vb[k], 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        #1;
        checkEq("t4_held", longint'(k), 3);
        checkEq("t4_in_ready", longint'(in_ready), 0);
        checkEq("t4_out_valid", longint'(out_valid), 1);
        for (int c = 0; c < 20 && k < 5; c++) begin
            step(1'b1, va[k], vb[k], 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        checkEq("t4_all_sent", longint'(k), 5);
        drain();

        // Case 5: flush a full pipe, then a fresh vector still takes 3 cycles.
        for (int c = 0; c < 3; c++) step(1'b1, randOp('0), randOp('0), 1'b0, 1'b0, acc);
        step(1'b1, '1, '1, 1'b0, 1'b1, acc);
        @(negedge clk); #1;
        checkEq("t5_flushed", longint'(out_valid), 0);
        @(posedge clk);
        step(1'b1, W'(1) << 20, W'(3) << 18, 1'b0, 1'b0, acc);
        waitOut(lat);
        checkEq("t5_latency", longint'(lat), 3);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        drain();

        // Randomised traffic with random backpressure and occasional flush.
        for (int c = 0; c < 800; c++) begin
            ra = randOp('0);
            rb = randOp(ra);
            step(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 49) == 0), acc);
        end
        drain();

        // Case 6: asynchronous reset mid-stream.
        for (int c = 0; c < 3; c++) step(1'b1, W'(1) << 30, W'(1) << 2, 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("t6_out_valid", longint'(out_valid), 0);
        checkEq("t6_ld", longint'(ld_count), 0);
        q.delete();
        stallPrev = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        step(1'b1, W'(1) << 40, '0, 1'b0, 1'b0, acc);
        waitOut(lat);
        checkEq("t6_latency", longint'(lat), 3);
        step(1'b0, '0, '0, 1'b1, 1'b0, acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
